// File: rtl/au_cnt_if.sv
// Control/status bundle for the au_cnt counter; master drives controls, slave is the counter.
interface au_cnt_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             en;
  logic             dn;
  logic [WIDTH-1:0] cnt;
  logic             at_max;
  logic             at_zero;
  logic             wrap;

  modport master (
    output clr, ld, ld_val, en, dn,
    input  cnt, at_max, at_zero, wrap
  );

  modport slave (
    input  clr, ld, ld_val, en, dn,
    output cnt, at_max, at_zero, wrap
  );
endinterface

// File: rtl/au_cnt.sv
// Up/down modulo counter on a prefix-tree incrementer/decrementer with load, clear and wrap/saturate.
// Latency 1 cycle control->cnt/wrap, at_max/at_zero combinational from cnt; no backpressure, acts every enabled edge.
module au_cnt #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int SAT   = 0,
  parameter int TOP   = 0
) (
  input logic   clk,
  input logic   rst_n,
  au_cnt_if.slave bus
);

  localparam longint unsigned FULL = (WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                   : ((64'd1 << WIDTH) - 64'd1);
  localparam logic [WIDTH-1:0] TOPV = (TOP == 0) ? {WIDTH{1'b1}} : WIDTH'(TOP);

  if ((WIDTH < 1) || (ARCH < 0) || (ARCH > 2) || ((SAT != 0) && (SAT != 1)) ||
      (TOP < 0) || (64'(TOP) > FULL)) begin : g_bad_param
    $fatal(1, "%m: illegal parameters WIDTH=%0d ARCH=%0d SAT=%0d TOP=%0d",
           WIDTH, ARCH, SAT, TOP);
  end

  // p[i] = &x[i:0]; the three networks differ only in depth/fanout, never in result.
  function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] p;
    p = x;
    if (ARCH == 0) begin
      for (int i = 1; i < WIDTH; i++) p[i] = p[i] & p[i-1];
    end else if (ARCH == 1) begin
      for (int d = 1; d < WIDTH; d = d * 2) begin
        logic [WIDTH-1:0] q;
        q = p;
        for (int i = d; i < WIDTH; i++) p[i] = q[i] & q[i-d];
      end
    end else begin
      for (int d = 1; d < WIDTH; d = d * 2) begin
        for (int i = 0; i < WIDTH; i++) begin
          if ((i & d) != 0) p[i] = p[i] & p[(i / (2 * d)) * (2 * d) + d - 1];
        end
      end
    end
    return p;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] up_pre, dn_pre, inc_v, dec_v, ld_clamp;
  logic             wrap_q, wrap_d;
  logic             hit_max, hit_zero;

  assign hit_max  = (cnt_q == TOPV);
  assign hit_zero = (cnt_q == '0);

  // Bit i flips when every lower bit is 1 (up) or 0 (down).
  assign up_pre = prefix_and(cnt_q);
  assign dn_pre = prefix_and(~cnt_q);
  assign inc_v  = cnt_q ^ ((up_pre << 1) | WIDTH'(1));
  assign dec_v  = cnt_q ^ ((dn_pre << 1) | WIDTH'(1));

  assign ld_clamp = (bus.ld_val > TOPV) ? TOPV : bus.ld_val;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.ld) begin
      cnt_d = ld_clamp;
    end else if (bus.en) begin
      if (!bus.dn) begin
        if (hit_max) begin
          cnt_d  = (SAT != 0) ? TOPV : '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = inc_v;
        end
      end else begin
        if (hit_zero) begin
          cnt_d  = (SAT != 0) ? '0 : TOPV;
          wrap_d = 1'b1;
        end else begin
          cnt_d = dec_v;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.at_max  = hit_max;
  assign bus.at_zero = hit_zero;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_au_cnt.sv
// Scoreboard bench for au_cnt: directed vectors on four fixed configs plus a random sweep over ARCH/WIDTH.
module tb_au_cnt;

  localparam int NI    = 13;
  localparam int NRAND = 10000;

  function automatic int cfg_w(int k);
    case (k)
      0, 1, 2:  return 4;
      3:        return 8;
      4, 7, 10: return 1;
      5, 8, 11: return 7;
      default:  return 16;
    endcase
  endfunction

  function automatic int cfg_arch(int k);
    if (k < 4) return (k == 3) ? 0 : k;
    return (k - 4) / 3;
  endfunction

  function automatic int cfg_sat(int k);
    case (k)
      2, 7, 8, 9, 11: return 1;
      default:        return 0;
    endcase
  endfunction

  function automatic int cfg_top(int k);
    case (k)
      1:       return 9;
      7:       return 1;
      8:       return 100;
      9:       return 50000;
      12:      return 40000;
      default: return 0;
    endcase
  endfunction

  function automatic string tname(int id);
    case (id)
      0:       return "reset_state";
      1:       return "reset_during_count";
      2:       return "up_wrap";
      3:       return "modulus_down_wrap";
      4:       return "saturate";
      5:       return "priority";
      6:       return "random_sweep";
      default: return "unknown";
    endcase
  endfunction

  typedef struct packed {
    int          tag;
    int          id;
    int          k;
    logic [15:0] cnt;
    logic        am;
    logic        az;
    logic        w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s [NI];
  logic        clr_s [NI];
  logic        ld_s  [NI];
  logic        en_s  [NI];
  logic        dn_s  [NI];
  logic [15:0] ldv_s [NI];
  logic [15:0] o_cnt [NI];
  logic        o_max [NI];
  logic        o_zero[NI];
  logic        o_wrap[NI];

  exp_t   sbq[$];
  int     tick   = 0;
  int     checks = 0;
  int     errors = 0;
  longint m_cnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = cfg_w(g);
    au_cnt_if #(.WIDTH(W)) ifc ();
    assign ifc.clr    = clr_s[g];
    assign ifc.ld     = ld_s[g];
    assign ifc.ld_val = ldv_s[g][W-1:0];
    assign ifc.en     = en_s[g];
    assign ifc.dn     = dn_s[g];
    au_cnt #(
      .WIDTH(W), .ARCH(cfg_arch(g)), .SAT(cfg_sat(g)), .TOP(cfg_top(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_s[g]),
      .bus  (ifc.slave)
    );
    assign o_cnt[g]  = 16'(ifc.cnt);
    assign o_max[g]  = ifc.at_max;
    assign o_zero[g] = ifc.at_zero;
    assign o_wrap[g] = ifc.wrap;
  end

  // Monitor: outputs are valid every half cycle; compare whatever is due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(clk);
      tick++;
      #1;
      while (sbq.size() > 0 && sbq[0].tag <= tick) begin
        e = sbq.pop_front();
        checks++;
        if (e.tag != tick || o_cnt[e.k] != e.cnt || o_max[e.k] != e.am ||
            o_zero[e.k] != e.az || o_wrap[e.k] != e.w) begin
          errors++;
          $display("FAIL %s inst%0d tick%0d: got cnt=%0d at_max=%0b at_zero=%0b wrap=%0b, want cnt=%0d at_max=%0b at_zero=%0b wrap=%0b",
                   tname(e.id), e.k, tick, o_cnt[e.k], o_max[e.k], o_zero[e.k], o_wrap[e.k],
                   e.cnt, e.am, e.az, e.w);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic drv(int k, bit c, bit l, int lv, bit e, bit d);
    clr_s[k] = c;
    ld_s[k]  = l;
    ldv_s[k] = 16'(lv);
    en_s[k]  = e;
    dn_s[k]  = d;
  endtask

  // Expected value of the outputs at the next clock edge.
  task automatic exp_next(int id, int k, longint c, bit am, bit az, bit w);
    exp_t e;
    e.tag = tick + 1;
    e.id  = id;
    e.k   = k;
    e.cnt = 16'(c);
    e.am  = am;
    e.az  = az;
    e.w   = w;
    sbq.push_back(e);
  endtask

  task automatic model_step(int k, bit c, bit l, int lv, bit e, bit d, output bit w);
    longint mask, tv, lvm;
    mask = (64'd1 << cfg_w(k)) - 1;
    tv   = (cfg_top(k) == 0) ? mask : longint'(cfg_top(k));
    lvm  = longint'(lv) & mask;
    w    = 1'b0;
    if (c) begin
      m_cnt[k] = 0;
    end else if (l) begin
      m_cnt[k] = (lvm > tv) ? tv : lvm;
    end else if (e && !d) begin
      if (m_cnt[k] == tv) begin
        m_cnt[k] = (cfg_sat(k) != 0) ? tv : 0;
        w = 1'b1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end else if (e && d) begin
      if (m_cnt[k] == 0) begin
        m_cnt[k] = (cfg_sat(k) != 0) ? 0 : tv;
        w = 1'b1;
      end else begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
    exp_next(6, k, m_cnt[k], m_cnt[k] == tv, m_cnt[k] == 0, w);
  endtask

  initial begin
    bit     rc, rl, re, rd, rw;
    int     rlv, r;
    for (int k = 0; k < NI; k++) begin
      rst_s[k] = 1'b1;
      drv(k, 0, 0, 0, 0, 0);
      m_cnt[k] = 0;
    end
    #1;
    for (int k = 0; k < NI; k++) rst_s[k] = 1'b0;

    nxt();
    for (int k = 0; k < 4; k++) exp_next(0, k, 0, 0, 1, 0);
    nxt();
    for (int k = 0; k < NI; k++) rst_s[k] = 1'b1;

    // Reset during count, asserted between clock edges.
    for (int i = 1; i <= 5; i++) begin
      nxt();
      drv(0, 0, 0, 0, 1, 0);
      exp_next(1, 0, i, 0, 0, 0);
    end
    @(posedge clk);
    #2;
    rst_s[0] = 1'b0;
    exp_next(1, 0, 0, 0, 1, 0);
    nxt();
    exp_next(1, 0, 0, 0, 1, 0);
    nxt();
    rst_s[0] = 1'b1;
    exp_next(1, 0, 1, 0, 0, 0);

    // Up wrap at full range.
    nxt(); drv(0, 0, 1, 14, 0, 0); exp_next(2, 0, 14, 0, 0, 0);
    nxt(); drv(0, 0, 0, 0, 1, 0);  exp_next(2, 0, 15, 1, 0, 0);
    nxt();                         exp_next(2, 0, 0, 0, 1, 1);
    nxt();                         exp_next(2, 0, 1, 0, 0, 0);
    nxt(); drv(0, 0, 0, 0, 0, 0);  exp_next(2, 0, 1, 0, 0, 0);

    // Modulus 9: clamped load, up wrap, down wrap.
    nxt(); drv(1, 0, 1, 12, 0, 0); exp_next(3, 1, 9, 1, 0, 0);
    nxt(); drv(1, 0, 0, 0, 1, 0);  exp_next(3, 1, 0, 0, 1, 1);
    nxt(); drv(1, 0, 0, 0, 1, 1);  exp_next(3, 1, 9, 1, 0, 1);
    nxt(); drv(1, 0, 0, 0, 0, 0);  exp_next(3, 1, 9, 1, 0, 0);

    // Saturation at both ends.
    nxt(); drv(2, 0, 1, 15, 0, 0); exp_next(4, 2, 15, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); drv(2, 0, 0, 0, 1, 0); exp_next(4, 2, 15, 1, 0, 1);
    end
    for (int i = 1; i <= 16; i++) begin
      nxt(); drv(2, 0, 0, 0, 1, 1);
      if (i < 16) exp_next(4, 2, 15 - i, 0, (i == 15), 0);
      else        exp_next(4, 2, 0, 0, 1, 1);
    end
    nxt(); drv(2, 0, 0, 0, 0, 0); exp_next(4, 2, 0, 0, 1, 0);

    // Control priority on the 8-bit counter.
    nxt(); drv(3, 0, 1, 'h33, 0, 0); exp_next(5, 3, 'h33, 0, 0, 0);
    nxt(); drv(3, 1, 1, 'h55, 1, 0); exp_next(5, 3, 0, 0, 1, 0);
    nxt(); drv(3, 0, 1, 'h55, 1, 0); exp_next(5, 3, 'h55, 0, 0, 0);
    nxt(); drv(3, 0, 0, 0, 1, 1);    exp_next(5, 3, 'h54, 0, 0, 0);
    nxt(); drv(3, 0, 1, 'hFF, 0, 0); exp_next(5, 3, 255, 1, 0, 0);
    nxt(); drv(3, 0, 0, 0, 1, 0);    exp_next(5, 3, 0, 0, 1, 1);
    nxt(); drv(3, 0, 0, 0, 1, 1);    exp_next(5, 3, 255, 1, 0, 1);
    nxt(); drv(3, 0, 0, 0, 0, 0);    exp_next(5, 3, 255, 1, 0, 0);

    // Random sweep: every ARCH at widths 1, 7, 16, run side by side.
    for (int n = 0; n < NRAND; n++) begin
      nxt();
      for (int k = 4; k < NI; k++) begin
        r   = $urandom_range(0, 15);
        rc  = (r == 0);
        rl  = (r == 1) || (r == 2);
        re  = ($urandom_range(0, 3) != 0);
        rd  = 1'($urandom_range(0, 1));
        rlv = $urandom_range(0, 65535);
        drv(k, rc, rl, rlv, re, rd);
        model_step(k, rc, rl, rlv, re, rd, rw);
      end
    end
    nxt();
    for (int k = 0; k < NI; k++) drv(k, 0, 0, 0, 0, 0);

    repeat (4) nxt();
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", sbq.size());
      errors += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
